// File: rtl/srm_pkg.sv
// Shared encodings and instruction field positions for the 16-bit
// instruction decoder and its queue.
package srm_pkg;

    localparam logic [2:0] OPC_MOV    = 3'b110;
    localparam logic [2:0] OPC_ALU    = 3'b101;
    localparam logic [1:0] OP_MOV_IMM = 2'b10;
    localparam logic [1:0] OP_MOV_REG = 2'b00;

    localparam logic [2:0] NSEL_RN = 3'b001;
    localparam logic [2:0] NSEL_RD = 3'b010;
    localparam logic [2:0] NSEL_RM = 3'b100;

    localparam int INST_W  = 16;
    localparam int OPC_HI  = 15;
    localparam int OPC_LO  = 13;
    localparam int OP_HI   = 12;
    localparam int OP_LO   = 11;
    localparam int RN_HI   = 10;
    localparam int RN_LO   = 8;
    localparam int RD_HI   = 7;
    localparam int RD_LO   = 5;
    localparam int SH_HI   = 4;
    localparam int SH_LO   = 3;
    localparam int RM_HI   = 2;
    localparam int RM_LO   = 0;
    localparam int IMM8_HI = 7;
    localparam int IMM5_HI = 4;

    function automatic logic is_legal(input logic [2:0] opc, input logic [1:0] op);
        return (opc == OPC_ALU) ||
               ((opc == OPC_MOV) && ((op == OP_MOV_IMM) || (op == OP_MOV_REG)));
    endfunction

endpackage

// File: rtl/instdec_field.sv
// Combinational field decoder for the head instruction; every decoded
// output except nsel_err is forced to zero while no instruction is present.
module instdec_field
    import srm_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic [INST_W-1:0] inst,
    input  logic              valid,
    input  logic [2:0]        nsel,
    output logic [2:0]        opcode,
    output logic [1:0]        op,
    output logic [1:0]        ALUop,
    output logic [1:0]        shift,
    output logic [DATA_W-1:0] sximm8,
    output logic [DATA_W-1:0] sximm5,
    output logic [2:0]        readnum,
    output logic [2:0]        writenum,
    output logic              illegal,
    output logic              nsel_err
);

    logic [2:0] w_regsel;

    always_comb begin
        w_regsel = 3'b000;
        nsel_err = 1'b0;
        case (nsel)
            NSEL_RN: w_regsel = inst[RN_HI:RN_LO];
            NSEL_RD: w_regsel = inst[RD_HI:RD_LO];
            NSEL_RM: w_regsel = inst[RM_HI:RM_LO];
            default: nsel_err = 1'b1;
        endcase
    end

    always_comb begin
        opcode   = 3'b000;
        op       = 2'b00;
        ALUop    = 2'b00;
        shift    = 2'b00;
        sximm8   = '0;
        sximm5   = '0;
        readnum  = 3'b000;
        writenum = 3'b000;
        illegal  = 1'b0;
        if (valid) begin
            opcode   = inst[OPC_HI:OPC_LO];
            op       = inst[OP_HI:OP_LO];
            ALUop    = inst[OP_HI:OP_LO];
            shift    = inst[SH_HI:SH_LO];
            sximm8   = {{(DATA_W-8){inst[IMM8_HI]}}, inst[IMM8_HI:0]};
            sximm5   = {{(DATA_W-5){inst[IMM5_HI]}}, inst[IMM5_HI:0]};
            readnum  = w_regsel;
            writenum = w_regsel;
            illegal  = ~is_legal(inst[OPC_HI:OPC_LO], inst[OP_HI:OP_LO]);
        end
    end

endmodule

// File: rtl/instdec_q.sv
// Instruction FIFO with a combinational decoder on the head entry.
// Full queue never bypasses: a pop while full frees the slot for the next cycle.
module instdec_q
    import srm_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       in_valid,
    input  logic [INST_W-1:0]          in_inst,
    output logic                       in_ready,
    output logic                       out_valid,
    input  logic                       out_ready,
    input  logic [2:0]                 nsel,
    output logic [2:0]                 opcode,
    output logic [1:0]                 op,
    output logic [1:0]                 ALUop,
    output logic [1:0]                 shift,
    output logic [DATA_W-1:0]          sximm8,
    output logic [DATA_W-1:0]          sximm5,
    output logic [2:0]                 readnum,
    output logic [2:0]                 writenum,
    output logic                       illegal,
    output logic                       nsel_err,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [INST_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wptr;
    logic [PTR_W-1:0]  r_rptr;
    logic [CNT_W-1:0]  r_count;
    logic              w_push;
    logic              w_pop;

    assign in_ready  = (r_count != FULL_CNT);
    assign out_valid = (r_count != '0);
    assign count     = r_count;
    assign w_push    = in_valid & in_ready;
    assign w_pop     = out_valid & out_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push)
                r_wptr <= r_wptr + 1'b1;
            if (w_pop)
                r_rptr <= r_rptr + 1'b1;
            if (w_push && !w_pop)
                r_count <= r_count + 1'b1;
            else if (w_pop && !w_push)
                r_count <= r_count - 1'b1;
        end
    end

    // Storage is not reset; pointers alone decide what is visible.
    always_ff @(posedge clk) begin
        if (w_push && !flush && !reset)
            r_mem[r_wptr] <= in_inst;
    end

    instdec_field #(
        .DATA_W (DATA_W)
    ) u_field (
        .inst     (r_mem[r_rptr]),
        .valid    (out_valid),
        .nsel     (nsel),
        .opcode   (opcode),
        .op       (op),
        .ALUop    (ALUop),
        .shift    (shift),
        .sximm8   (sximm8),
        .sximm5   (sximm5),
        .readnum  (readnum),
        .writenum (writenum),
        .illegal  (illegal),
        .nsel_err (nsel_err)
    );

endmodule

// File: tb/tb_instdec_q.sv
// Scenario bench for instdec_q: a queue of expected instruction words is
// filled on every accepted push and drained as the DUT presents its head.
module tb_instdec_q;

    localparam int DEPTH = 4;
    localparam int CW    = 3;

    logic        clk = 1'b0;
    logic        reset, flush, in_valid, out_ready;
    logic [15:0] in_inst;
    logic [2:0]  nsel;

    logic          in_ready, out_valid, illegal, nsel_err;
    logic [2:0]    opcode, readnum, writenum;
    logic [1:0]    op, ALUop, shift;
    logic [15:0]   sximm8, sximm5;
    logic [CW-1:0] count;

    logic          b_in_ready, b_out_valid, b_illegal, b_nsel_err;
    logic [2:0]    b_opcode, b_readnum, b_writenum;
    logic [1:0]    b_op, b_ALUop, b_shift;
    logic [31:0]   b_sximm8, b_sximm5;
    logic [CW-1:0] b_count;

    int errors = 0;
    int checks = 0;
    logic [15:0] sb_q[$];
    logic [15:0] exp_w, got_w;

    always #5 clk = ~clk;

    instdec_q #(.DEPTH(DEPTH), .DATA_W(16)) u_dut (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_inst(in_inst),
        .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready), .nsel(nsel),
        .opcode(opcode), .op(op), .ALUop(ALUop), .shift(shift), .sximm8(sximm8),
        .sximm5(sximm5), .readnum(readnum), .writenum(writenum), .illegal(illegal),
        .nsel_err(nsel_err), .count(count)
    );

    instdec_q #(.DEPTH(DEPTH), .DATA_W(32)) u_dut32 (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_inst(in_inst),
        .in_ready(b_in_ready), .out_valid(b_out_valid), .out_ready(out_ready), .nsel(nsel),
        .opcode(b_opcode), .op(b_op), .ALUop(b_ALUop), .shift(b_shift), .sximm8(b_sximm8),
        .sximm5(b_sximm5), .readnum(b_readnum), .writenum(b_writenum), .illegal(b_illegal),
        .nsel_err(b_nsel_err), .count(b_count)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_inst = 16'h0000; nsel = 3'b001;
        step; step;
        reset = 1'b0;
        step;
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", count); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++;
        if ({opcode, op, shift, sximm8, sximm5, readnum, illegal} !== '0) begin
            errors++; $display("FAIL reset_decoded got=%h exp=0", {opcode, op, shift, sximm8, sximm5, readnum, illegal});
        end
    endtask

    task automatic test_single;
        in_inst = 16'b1101000001010101; in_valid = 1'b1; nsel = 3'b001;
        sb_q.push_back(in_inst);
        step;
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid got=%b exp=1", out_valid); end
        checks++; if (opcode !== 3'b110) begin errors++; $display("FAIL single_opcode got=%b exp=110", opcode); end
        checks++; if (op !== 2'b10 || ALUop !== 2'b10) begin errors++; $display("FAIL single_op got=%b/%b exp=10", op, ALUop); end
        checks++; if (readnum !== 3'b000 || writenum !== 3'b000) begin errors++; $display("FAIL single_readnum got=%b exp=000", readnum); end
        checks++; if (sximm8 !== 16'h0055) begin errors++; $display("FAIL single_sximm8 got=%h exp=0055", sximm8); end
        checks++; if (sximm5 !== 16'hFFF5) begin errors++; $display("FAIL single_sximm5 got=%h exp=fff5", sximm5); end
        checks++; if (shift !== 2'b10) begin errors++; $display("FAIL single_shift got=%b exp=10", shift); end
        checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL single_illegal got=%b exp=0", illegal); end
        checks++; if (count !== 3'd1) begin errors++; $display("FAIL single_count got=%0d exp=1", count); end
        out_ready = 1'b1;
        exp_w = sb_q.pop_front();
        step;
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_popped got=%b exp=0", out_valid); end
    endtask

    task automatic test_sign_ext;
        in_inst = 16'b1101000010000001; in_valid = 1'b1;
        step;
        in_valid = 1'b0;
        checks++; if (sximm8 !== 16'hFF81) begin errors++; $display("FAIL sext_imm8 got=%h exp=ff81", sximm8); end
        checks++; if (sximm5 !== 16'h0001) begin errors++; $display("FAIL sext_imm5 got=%h exp=0001", sximm5); end
        checks++; if (b_sximm8 !== 32'hFFFFFF81) begin errors++; $display("FAIL sext_imm8_w32 got=%h exp=ffffff81", b_sximm8); end
        checks++; if (b_sximm5 !== 32'h00000001) begin errors++; $display("FAIL sext_imm5_w32 got=%h exp=00000001", b_sximm5); end
        in_inst = 16'b1011000000011111; in_valid = 1'b1; out_ready = 1'b1;
        step;
        in_valid = 1'b0;
        checks++; if (sximm5 !== 16'hFFFF || sximm8 !== 16'h001F) begin errors++; $display("FAIL sext_imm5_neg got=%h/%h exp=ffff/001f", sximm5, sximm8); end
        step;
        out_ready = 1'b0;
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL sext_drain got=%0d exp=0", count); end
    endtask

    task automatic test_fill_wrap;
        nsel = 3'b001; out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_inst = 16'($urandom); in_valid = 1'b1;
            checks++;
            if (in_ready !== (i < 4)) begin errors++; $display("FAIL fill_ready_%0d got=%b exp=%b", i, in_ready, (i < 4)); end
            if (i < 4) sb_q.push_back(in_inst);
            step;
        end
        in_valid = 1'b0;
        checks++; if (count !== 3'd4) begin errors++; $display("FAIL fill_count got=%0d exp=4", count); end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp_w = sb_q.pop_front();
            got_w = {opcode, op, readnum, sximm8[7:0]};
            checks++;
            if (out_valid !== 1'b1 || got_w !== exp_w) begin errors++; $display("FAIL drain_%0d got=%h exp=%h", i, got_w, exp_w); end
            step;
        end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL drain_empty got=%b exp=0", out_valid); end
        for (int i = 0; i < 8; i++) begin
            in_valid = (i < 6);
            in_inst = 16'($urandom);
            if (out_valid) begin
                exp_w = (sb_q.size() > 0) ? sb_q.pop_front() : 16'hxxxx;
                got_w = {opcode, op, readnum, sximm8[7:0]};
                checks++;
                if (got_w !== exp_w) begin errors++; $display("FAIL wrap_%0d got=%h exp=%h", i, got_w, exp_w); end
            end
            if (in_valid && in_ready) sb_q.push_back(in_inst);
            step;
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        checks++; if (count !== 3'd0 || sb_q.size() != 0) begin errors++; $display("FAIL wrap_end got=%0d exp=0 left=%0d", count, sb_q.size()); end
    endtask

    task automatic test_simul_flush;
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_inst = 16'hA000 + 16'(i); in_valid = 1'b1;
            sb_q.push_back(in_inst);
            step;
        end
        checks++; if (count !== 3'd2) begin errors++; $display("FAIL simul_pre got=%0d exp=2", count); end
        in_inst = 16'hA0F2; in_valid = 1'b1; out_ready = 1'b1;
        exp_w = sb_q.pop_front();
        got_w = {opcode, op, readnum, sximm8[7:0]};
        checks++; if (got_w !== exp_w) begin errors++; $display("FAIL simul_head got=%h exp=%h", got_w, exp_w); end
        sb_q.push_back(in_inst);
        step;
        out_ready = 1'b0;
        checks++; if (count !== 3'd2) begin errors++; $display("FAIL simul_count got=%0d exp=2", count); end
        exp_w = sb_q[0];
        got_w = {opcode, op, readnum, sximm8[7:0]};
        checks++; if (got_w !== exp_w) begin errors++; $display("FAIL simul_next got=%h exp=%h", got_w, exp_w); end
        flush = 1'b1; in_inst = 16'hBEEF; in_valid = 1'b1; out_ready = 1'b1;
        step;
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        sb_q.delete();
        checks++; if (count !== 3'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL flush_count got=%0d/%b exp=0/0", count, out_valid); end
        step;
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL flush_dropped got=%0d exp=0", count); end
    endtask

    task automatic test_select_illegal;
        in_inst = 16'b1010000101001000; in_valid = 1'b1; nsel = 3'b010;
        step;
        in_valid = 1'b0;
        checks++; if (readnum !== 3'b010 || writenum !== 3'b010) begin errors++; $display("FAIL sel_rd got=%b/%b exp=010", readnum, writenum); end
        checks++; if (nsel_err !== 1'b0 || illegal !== 1'b0) begin errors++; $display("FAIL sel_rd_flags got=%b/%b exp=0/0", nsel_err, illegal); end
        nsel = 3'b001; #1;
        checks++; if (readnum !== 3'b001) begin errors++; $display("FAIL sel_rn got=%b exp=001", readnum); end
        nsel = 3'b100; #1;
        checks++; if (readnum !== 3'b000 || nsel_err !== 1'b0) begin errors++; $display("FAIL sel_rm got=%b/%b exp=000/0", readnum, nsel_err); end
        nsel = 3'b111; #1;
        checks++; if (readnum !== 3'b000 || writenum !== 3'b000 || nsel_err !== 1'b1) begin errors++; $display("FAIL sel_bad got=%b/%b exp=000/1", readnum, nsel_err); end
        nsel = 3'b000; #1;
        checks++; if (nsel_err !== 1'b1) begin errors++; $display("FAIL sel_zero got=%b exp=1", nsel_err); end
        nsel = 3'b001; out_ready = 1'b1;
        in_inst = 16'h0000; in_valid = 1'b1;
        step;
        in_inst = 16'b1100100000000000;
        checks++; if (illegal !== 1'b1 || out_valid !== 1'b1) begin errors++; $display("FAIL illegal_zero got=%b exp=1", illegal); end
        step;
        in_valid = 1'b0;
        checks++; if (illegal !== 1'b1 || opcode !== 3'b110) begin errors++; $display("FAIL illegal_mov01 got=%b exp=1", illegal); end
        step;
        out_ready = 1'b0;
        nsel = 3'b011; #1;
        checks++; if (out_valid !== 1'b0 || nsel_err !== 1'b1 || readnum !== 3'b000 || illegal !== 1'b0) begin
            errors++; $display("FAIL sel_empty got=%b/%b/%b exp=0/1/000", out_valid, nsel_err, readnum);
        end
        nsel = 3'b001;
    endtask

    task automatic test_async_reset;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_inst = 16'hC000 + 16'(i); in_valid = 1'b1;
            step;
        end
        in_valid = 1'b0;
        checks++; if (count !== 3'd3) begin errors++; $display("FAIL areset_pre got=%0d exp=3", count); end
        #3;
        reset = 1'b1;
        #1;
        checks++; if (count !== 3'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL areset_now got=%0d/%b/%b exp=0/0/1", count, out_valid, in_ready);
        end
        checks++; if ({opcode, op, sximm8, readnum} !== '0) begin errors++; $display("FAIL areset_dec got=%h exp=0", {opcode, op, sximm8, readnum}); end
        in_valid = 1'b1;
        step;
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL areset_hold got=%0d exp=0", count); end
        in_valid = 1'b0;
        reset = 1'b0;
        step;
        checks++; if (count !== 3'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL areset_after got=%0d exp=0", count); end
    endtask

    initial begin
        test_reset;
        test_single;
        test_sign_ext;
        test_fill_wrap;
        test_simul_flush;
        test_select_illegal;
        test_async_reset;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/instdec_q.md
INSTDEC_Q -- requirements
Module: instdec_q

Interface
REQ-001 Parameter DEPTH, default 4, instruction queue entries; SHALL be a power of two, >= 2.
REQ-002 Parameter DATA_W, default 16, width of sign-extended immediates; SHALL be >= 8.
REQ-003 clk  input  1  single clock, all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 flush  input  1  synchronous queue clear.
REQ-006 in_valid  input  1  in_inst holds an instruction.
REQ-007 in_inst  input  16  instruction word.
REQ-008 in_ready  output  1  queue can accept an instruction.
REQ-009 out_valid  output  1  decoded head instruction present.
REQ-010 out_ready  input  1  consumer accepts the head instruction.
REQ-011 nsel  input  3  register select, one-hot: 001=Rn, 010=Rd, 100=Rm.
REQ-012 opcode  output  3  head bits [15:13].
REQ-013 op  output  2  head bits [12:11].
REQ-014 ALUop  output  2  head bits [12:11].
REQ-015 shift  output  2  head bits [4:3].
REQ-016 sximm8  output  DATA_W  head bits [7:0], sign-extended.
REQ-017 sximm5  output  DATA_W  head bits [4:0], sign-extended.
REQ-018 readnum  output  3  register number selected by nsel.
REQ-019 writenum  output  3  same value as readnum.
REQ-020 illegal  output  1  head is not a supported encoding.
REQ-021 nsel_err  output  1  nsel is not one-hot.
REQ-022 count  output  $clog2(DEPTH+1)  current occupancy.

Function
REQ-023 The queue SHALL be FIFO-ordered.
- push = in_valid & in_ready.
- pop = out_valid & out_ready.
REQ-024 in_ready SHALL equal (count != DEPTH).
- No write-through bypass when full, even if a pop occurs in the same cycle.
REQ-025 out_valid SHALL equal (count != 0).
- An instruction pushed at edge N SHALL appear on the outputs immediately after edge N (1-cycle latency).
REQ-026 Simultaneous push and pop with 0 < count < DEPTH SHALL leave count unchanged and advance both pointers.
REQ-027 Read and write pointers SHALL be $clog2(DEPTH) bits and wrap modulo DEPTH.
REQ-028 flush=1 SHALL set count and both pointers to 0 at the next edge, overriding push and pop in that cycle.
REQ-029 Decoded outputs SHALL be combinational from the head entry.
- When out_valid=0, opcode, op, ALUop, shift, sximm8, sximm5 and illegal SHALL all be 0.
REQ-030 Register field selection:
- nsel=001 -> bits [10:8] (Rn).
- nsel=010 -> bits [7:5] (Rd).
- nsel=100 -> bits [2:0] (Rm).
- Any other nsel -> readnum=writenum=0 and nsel_err=1.
- nsel_err SHALL be 0 otherwise.
- readnum and writenum SHALL be 0 when out_valid=0; nsel_err is independent of out_valid.
REQ-031 illegal SHALL be 1 when out_valid=1 and {opcode,op} is not one of: 110/10 (MOV imm), 110/00 (MOV reg), 101/xx (ALU).
- Illegal instructions SHALL still be queued and popped normally.
REQ-032 Sign extension SHALL replicate bit 7 (sximm8) or bit 4 (sximm5) into all upper bits up to DATA_W-1.

Reset
REQ-033 reset=1 SHALL asynchronously clear count and both pointers.
- Resulting outputs: in_ready=1, out_valid=0, all decoded outputs 0.
- Storage contents need not be cleared.
REQ-034 Reset asserted mid-transfer SHALL discard all queued instructions.
- No push or pop SHALL occur on any edge while reset=1.

Structure
REQ-035 Shared package srm_pkg SHALL hold:
- opcode constants OPC_MOV=3'b110 and OPC_ALU=3'b101;
- nsel constants NSEL_RN, NSEL_RD, NSEL_RM;
- field bit-position localparams.
REQ-036 The combinational field decoder SHALL be the single sub-module instdec_field, parameterised by DATA_W and instantiated once on the head entry.

Verification
REQ-037 The bench SHALL cover at least these directed scenarios:
- Single instruction: push 16'b1101000001010101 with nsel=001, DATA_W=16 -> next cycle out_valid=1, opcode=110, op=10, readnum=000, sximm8=16'h0055, illegal=0.
- Sign extension: push 16'b1101000010000001 -> sximm8=16'hFF81, sximm5=16'h0001; repeat with DATA_W=32 -> sximm8=32'hFFFFFF81.
- Fill and wrap: DEPTH=4, out_ready=0, push 5 words -> in_ready=0 after the 4th and the 5th is not accepted; then drain 4 -> words emerge in push order; then push and pop 6 more across the pointer wrap -> order preserved.
- Simultaneous and flush: count=2 with push and pop in the same cycle -> count stays 2; flush with push=1 -> count=0 next cycle and the pushed word is dropped.
- Select and illegal: head 16'b1010000101001000 with nsel=010 -> readnum=writenum=010; nsel=111 -> readnum=0, nsel_err=1; head 16'b0000000000000000 -> illegal=1.
- Reset: assert reset asynchronously between edges with count=3 -> count=0, out_valid=0, in_ready=1 immediately, before the next edge.
